// File: rtl/xbuf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xbuf_pkg                                                     |
// | Description : Shared types and constants for the x activation buffer       |
// |               responder.                                                   |
// |               - xb_state_e : buffer FSM states                             |
// |               - word_t     : one buffer word at the default geometry       |
// |                              (4 elements x 16 bits)                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package xbuf_pkg;

    // Default buffer word geometry; the RTL itself is parameterised and only
    // the bench relies on word_t.
    localparam int c_xb_data_width = 16;
    localparam int c_xb_data_num   = 4;
    localparam int c_xb_word_w     = c_xb_data_width * c_xb_data_num;

    typedef logic [c_xb_word_w-1:0] word_t;

    // Buffer FSM states, explicitly encoded.
    typedef enum logic [1:0] {
        XB_IDLE  = 2'd0,
        XB_LOAD  = 2'd1,
        XB_READY = 2'd2
    } xb_state_e;

endpackage : xbuf_pkg
`default_nettype wire

// File: rtl/xbuf_lat_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xbuf_lat_pipe                                                |
// | Description : Fixed-latency response pipeline for buffer reads.            |
// |               Stage 1 captures the memory read word and the request        |
// |               {valid, err} flags; the last stage drives the response.      |
// |               Data in each stage only advances on a good response, so the  |
// |               output word holds its value between o_ok pulses.             |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               i_req  - request accepted this cycle                         |
// |               i_err  - request is rejected                                 |
// |               i_data - memory word read for this request                   |
// |               o_x    - response word (held between good responses)         |
// |               o_ok   - good response this cycle                            |
// |               o_err  - rejected response this cycle                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module xbuf_lat_pipe
    import xbuf_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic             i_err,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_x,
    output logic             o_ok,
    output logic             o_err
);

    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_err;
    logic [WIDTH-1:0]  r_data [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_err <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_req;
            r_err[0] <= i_err;
            if (i_req && !i_err) begin
                r_data[0] <= i_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                // Rejected or empty slots leave the data untouched so that the
                // last stage keeps the previous good word.
                if (r_vld[i-1] && !r_err[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_x   = r_data[RD_LAT-1];
    assign o_ok  = r_vld[RD_LAT-1] & ~r_err[RD_LAT-1];
    assign o_err = r_vld[RD_LAT-1] &  r_err[RD_LAT-1];

endmodule : xbuf_lat_pipe
`default_nettype wire

// File: rtl/x_buf_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : x_buf_responder                                              |
// | Description : Memory-side responder for the x read channel. Holds the      |
// |               activation buffer, filled word by word through a host load   |
// |               port, then read by the attention core with a fixed latency   |
// |               of RD_LAT cycles and a throughput of one read per cycle.     |
// |               Reads while not loaded or beyond the loaded length are       |
// |               answered with rd_err instead of x_ok.                        |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               ld_start/ld_len      - start a load of ld_len words          |
// |               ld_valid/ld_data     - load word, accepted with ld_ready     |
// |               ld_ready             - high while loading                    |
// |               ld_done              - pulse after the last word is written  |
// |               x_ren/x_cs/x_rd_addr - read request (x_cs & x_ren)           |
// |               x/x_ok/rd_err        - read response after RD_LAT cycles     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module x_buf_responder
    import xbuf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_NUM   = 4,
    parameter int ADDR_W     = 13,
    parameter int DEPTH      = 8192,
    parameter int RD_LAT     = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ld_start,
    input  logic [ADDR_W:0]                ld_len,
    input  logic                           ld_valid,
    input  logic [DATA_NUM*DATA_WIDTH-1:0] ld_data,
    output logic                           ld_ready,
    output logic                           ld_done,
    input  logic                           x_ren,
    input  logic                           x_cs,
    input  logic [ADDR_W-1:0]              x_rd_addr,
    output logic [DATA_NUM*DATA_WIDTH-1:0] x,
    output logic                           x_ok,
    output logic                           rd_err
);

    localparam int              c_word_w = DATA_NUM * DATA_WIDTH;
    localparam logic [ADDR_W:0] c_depth  = (ADDR_W+1)'(DEPTH);

    xb_state_e         r_state;
    xb_state_e         w_next_state;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   w_next_wr_ptr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   w_next_len;
    logic              r_ld_done;
    logic              w_next_ld_done;
    logic              w_wr_en;
    logic [ADDR_W:0]   w_ld_len_clamped;
    logic              w_req;
    logic              w_hit;
    logic [c_word_w-1:0] w_rd_word;

    logic [c_word_w-1:0] r_mem [DEPTH];

    // Host may ask for more words than the buffer holds; only DEPTH are taken.
    assign w_ld_len_clamped = (ld_len > c_depth) ? c_depth : ld_len;

    assign w_req = x_cs & x_ren;
    // Both the state and the length are the values of the request cycle, so a
    // reload started in the same cycle does not affect this read.
    assign w_hit = (r_state == XB_READY) && ({1'b0, x_rd_addr} < r_len);

    assign ld_ready = (r_state == XB_LOAD);
    assign ld_done  = r_ld_done;

    // ------------------------------------------------------------------------
    // FSM: next state, load counter and length
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_next_wr_ptr  = r_wr_ptr;
        w_next_len     = r_len;
        w_next_ld_done = 1'b0;
        w_wr_en        = 1'b0;
        case (r_state)
            XB_IDLE, XB_READY: begin
                if (ld_start) begin
                    if (ld_len == '0) begin
                        w_next_ld_done = 1'b1;
                    end else begin
                        w_next_state  = XB_LOAD;
                        w_next_wr_ptr = '0;
                        w_next_len    = w_ld_len_clamped;
                    end
                end
            end
            XB_LOAD: begin
                // ld_ready is high for the whole state, so ld_valid alone
                // qualifies a write; ld_start is ignored here.
                if (ld_valid) begin
                    w_wr_en       = 1'b1;
                    w_next_wr_ptr = r_wr_ptr + 1'b1;
                    if (r_wr_ptr == r_len - 1'b1) begin
                        w_next_state   = XB_READY;
                        w_next_ld_done = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = XB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= XB_IDLE;
            r_wr_ptr  <= '0;
            r_len     <= '0;
            r_ld_done <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_wr_ptr  <= w_next_wr_ptr;
            r_len     <= w_next_len;
            r_ld_done <= w_next_ld_done;
        end
    end

    // ------------------------------------------------------------------------
    // Buffer storage. Writes happen only in LOAD and good reads only in READY,
    // so a single port never sees both in the same cycle. Contents are not
    // reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= ld_data;
        end
    end

    assign w_rd_word = r_mem[x_rd_addr];

    // ------------------------------------------------------------------------
    // Response pipeline; stage 1 registers the memory word at the edge that
    // ends the request cycle.
    // ------------------------------------------------------------------------
    xbuf_lat_pipe #(
        .WIDTH  (c_word_w),
        .RD_LAT (RD_LAT)
    ) u_lat_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (w_req),
        .i_err  (~w_hit),
        .i_data (w_rd_word),
        .o_x    (x),
        .o_ok   (x_ok),
        .o_err  (rd_err)
    );

endmodule : x_buf_responder
`default_nettype wire
